prio_encoder_casez: RTL and testbench



---
 rtl/prio_encoder_casez_if.sv | 28 ++
 rtl/prio_encoder_casez.sv | 54 +++++
 tb/tb_prio_encoder_casez.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/prio_encoder_casez_if.sv
// Request/result bundle for the registered priority encoder.
// No latency of its own; it only carries signals.
// No backpressure: requests are sampled every cycle.
interface prio_encoder_casez_if #(
  parameter int N  = 4,
  parameter int YW = 3
);
  logic [N:1]    r_amisha;
  logic [YW-1:0] y_amisha;
  logic          valid_amisha;
  logic [N:1]    grant_amisha;

  // Request source: drives requests, observes the encoded result.
  modport master (
    output r_amisha,
    input  y_amisha,
    input  valid_amisha,
    input  grant_amisha
  );

  // Encoder side: consumes requests, produces the registered result.
  modport slave (
    input  r_amisha,
    output y_amisha,
    output valid_amisha,
    output grant_amisha
  );
endinterface

// File: rtl/prio_encoder_casez.sv
// Registered priority encoder: index (1..N) of highest set request, 0 if none.
// Latency: one clk_amisha cycle from request sample to outputs.
// No backpressure: a new result is loaded on every non-reset edge.
module prio_encoder_casez #(
  parameter int N  = 4,
  parameter int YW = 3
) (
  input logic                clk_amisha,
  input logic                reset_amisha,
  prio_encoder_casez_if.slave bus
);

  // The code must be able to represent every index 1..N plus the idle value 0.
  if (N < 1 || N > 15 || (1 << YW) <= N) begin : g_bad_cfg
    $error("prio_encoder_casez: illegal N/YW combination");
  end

  logic [YW-1:0] y_next;
  logic          valid_next;
  logic [N:1]    grant_next;

  // Scan upward so the highest set bit is the last assignment and wins;
  // lower bits are effectively don't-care once a higher one is set.
  always_comb begin
    y_next     = '0;
    grant_next = '0;
    for (int i = 1; i <= N; i++) begin
      if (bus.r_amisha[i]) begin
        y_next        = YW'(i);
        grant_next    = '0;
        grant_next[i] = 1'b1;
      end
    end
  end

  // Any request at all makes the result valid.
  always_comb begin
    valid_next = |bus.r_amisha;
  end

  // Output register; reset wins over any request in the same cycle.
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      bus.y_amisha     <= '0;
      bus.valid_amisha <= 1'b0;
      bus.grant_amisha <= '0;
    end else begin
      bus.y_amisha     <= y_next;
      bus.valid_amisha <= valid_next;
      bus.grant_amisha <= grant_next;
    end
  end

endmodule

// File: tb/tb_prio_encoder_casez.sv
// Self-checking bench for prio_encoder_casez at N=4/YW=3 and N=7/YW=3.
// Results are checked one clock after each request is applied.
// No backpressure exists; one request pattern is applied per cycle.
module tb_prio_encoder_casez;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  prio_encoder_casez_if #(.N(4), .YW(3)) bus4 ();
  prio_encoder_casez_if #(.N(7), .YW(3)) bus7 ();

  prio_encoder_casez #(.N(4), .YW(3)) dut4 (
    .clk_amisha  (clk),
    .reset_amisha(rst),
    .bus         (bus4)
  );

  prio_encoder_casez #(.N(7), .YW(3)) dut7 (
    .clk_amisha  (clk),
    .reset_amisha(rst),
    .bus         (bus7)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [3:0] r;
    logic [2:0] y;
    logic       v;
    logic [3:0] g;
  } vec_t;

  vec_t tbl[12];

  // Expected code = bit length of the request word (0 for no request).
  function automatic int ref_y(input int r);
    int n;
    int t;
    n = 0;
    t = r;
    while (t > 0) begin
      t = t / 2;
      n++;
    end
    return n;
  endfunction

  function automatic int ref_g(input int r);
    int y;
    y = ref_y(r);
    return (y == 0) ? 0 : (1 << (y - 1));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string name, input int y, input int v, input int g);
    chk({name, ".y4"}, int'(bus4.y_amisha), y);
    chk({name, ".v4"}, int'(bus4.valid_amisha), v);
    chk({name, ".g4"}, int'(bus4.grant_amisha), g);
  endtask

  task automatic chk7(input string name, input int r);
    chk({name, ".y7"}, int'(bus7.y_amisha), ref_y(r));
    chk({name, ".v7"}, int'(bus7.valid_amisha), (r != 0) ? 1 : 0);
    chk({name, ".g7"}, int'(bus7.grant_amisha), ref_g(r));
  endtask

  initial begin
    tbl[0]  = '{4'd0,  3'd0, 1'b0, 4'd0};
    tbl[1]  = '{4'd1,  3'd1, 1'b1, 4'd1};
    tbl[2]  = '{4'd2,  3'd2, 1'b1, 4'd2};
    tbl[3]  = '{4'd3,  3'd2, 1'b1, 4'd2};
    tbl[4]  = '{4'd4,  3'd3, 1'b1, 4'd4};
    tbl[5]  = '{4'd5,  3'd3, 1'b1, 4'd4};
    tbl[6]  = '{4'd7,  3'd3, 1'b1, 4'd4};
    tbl[7]  = '{4'd8,  3'd4, 1'b1, 4'd8};
    tbl[8]  = '{4'd9,  3'd4, 1'b1, 4'd8};
    tbl[9]  = '{4'd15, 3'd4, 1'b1, 4'd8};
    tbl[10] = '{4'd6,  3'd3, 1'b1, 4'd4};
    tbl[11] = '{4'd1,  3'd1, 1'b1, 4'd1};

    // Reset held with every request asserted.
    rst            = 1'b1;
    bus4.r_amisha  = 4'hF;
    bus7.r_amisha  = 7'h7F;
    step();
    chk4("rst_c1", 0, 0, 0);
    chk7("rst_c1", 0);
    step();
    chk4("rst_c2", 0, 0, 0);
    chk7("rst_c2", 0);

    // First edge after release loads the live requests, no idle cycle.
    rst = 1'b0;
    step();
    chk4("post_rst", 4, 1, 8);
    chk7("post_rst", 127);

    // Sweep and one-hot grant table, one pattern per clock.
    for (int i = 0; i < 12; i++) begin
      bus4.r_amisha = tbl[i].r;
      step();
      chk4($sformatf("tbl%0d", i), int'(tbl[i].y), int'(tbl[i].v), int'(tbl[i].g));
    end

    // Latency: a change between edges is invisible until the next edge.
    bus4.r_amisha = 4'd0;
    step();
    chk4("lat_idle", 0, 0, 0);
    bus4.r_amisha = 4'd8;
    @(negedge clk);
    chk("lat_hold.y4", int'(bus4.y_amisha), 0);
    step();
    chk4("lat_load", 4, 1, 8);

    // Mid-stream single-cycle reset.
    bus4.r_amisha = 4'd5;
    bus7.r_amisha = 7'd5;
    step();
    chk4("mid_pre", 3, 1, 4);
    chk7("mid_pre", 5);
    rst = 1'b1;
    step();
    chk4("mid_rst", 0, 0, 0);
    chk7("mid_rst", 0);
    rst = 1'b0;
    step();
    chk4("mid_post", 3, 1, 4);
    chk7("mid_post", 5);

    // Exhaustive sweep of both builds, back-to-back values.
    for (int v = 0; v < 128; v++) begin
      bus4.r_amisha = 4'(v % 16);
      bus7.r_amisha = 7'(v);
      step();
      chk4($sformatf("ex%0d", v), ref_y(v % 16), (v % 16 != 0) ? 1 : 0, ref_g(v % 16));
      chk7($sformatf("ex%0d", v), v);
    end

    // Randomized requests against the reference model.
    for (int k = 0; k < 200; k++) begin
      int r4;
      int r7;
      r4 = int'($urandom_range(0, 15));
      r7 = int'($urandom_range(0, 127));
      bus4.r_amisha = 4'(r4);
      bus7.r_amisha = 7'(r7);
      step();
      chk4($sformatf("rnd%0d", k), ref_y(r4), (r4 != 0) ? 1 : 0, ref_g(r4));
      chk7($sformatf("rnd%0d", k), r7);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
